// File: rtl/scrambler_66_64.sv
// 64b/66b TX self-synchronous scrambler, G(x) = 1 + x^39 + x^58, 64 bits per clock.
// The payload is scrambled and the sync header passes through untouched.
// There is one registered output stage with valid/ready on both sides.
module scrambler_66_64 #(
  parameter logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_header,
  input  logic        scr_bypass,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [1:0]  out_header,
  output logic        hdr_err
);

  // Scrambler history: state_reg[j] is bit j+6 of the previous scrambled word.
  logic [57:0] state_reg;
  logic        out_valid_reg, out_valid_next;
  logic [63:0] out_data_reg, out_data_next;
  logic [1:0]  out_header_reg, out_header_next;
  logic        hdr_err_reg, hdr_err_next;
  logic [57:0] state_next;

  // The scrambled word is split into three slices so that no vector depends on itself:
  // bits 0..38 come only from the history,
  // bits 39..57 fold in the low slice,
  // bits 58..63 fold in the low slice twice.
  logic [38:0] s_lo;
  logic [18:0] s_mid;
  logic [5:0]  s_hi;
  logic [63:0] scr_word;
  logic        accept;
  logic        hdr_bad;

  generate
    for (genvar gi = 0; gi < 39; gi++) begin : g_lo
      assign s_lo[gi] = in_data[gi] ^ state_reg[gi] ^ state_reg[gi+19];
    end
    for (genvar gi = 0; gi < 19; gi++) begin : g_mid
      assign s_mid[gi] = in_data[gi+39] ^ s_lo[gi] ^ state_reg[gi+39];
    end
    for (genvar gi = 0; gi < 6; gi++) begin : g_hi
      assign s_hi[gi] = in_data[gi+58] ^ s_lo[gi+19] ^ s_lo[gi];
    end
  endgenerate

  assign scr_word = {s_hi, s_mid, s_lo};
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign hdr_bad  = (in_header[1] == in_header[0]);

  // Next-state for the output stage and scrambler history; stalls hold everything.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_header_next = out_header_reg;
    hdr_err_next    = hdr_err_reg;
    state_next      = state_reg;
    if (accept) begin
      out_valid_next  = 1'b1;
      out_data_next   = scr_bypass ? in_data : scr_word;
      out_header_next = in_header;
      hdr_err_next    = hdr_bad;
      // The history advances even in bypass so scrambling resumes seamlessly.
      state_next      = scr_word[63:6];
    end else if (out_ready) begin
      out_valid_next  = 1'b0;
    end
  end

  // Register the output stage and history; reset drops any held beat.
  always_ff @(posedge CLK) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= 64'd0;
      out_header_reg <= 2'd0;
      hdr_err_reg    <= 1'b0;
      state_reg      <= SEED;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_header_reg <= out_header_next;
      hdr_err_reg    <= hdr_err_next;
      state_reg      <= state_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_header = out_header_reg;
  assign hdr_err    = hdr_err_reg;

endmodule

// File: tb/tb_scrambler_66_64.sv
// Scoreboard bench for scrambler_66_64.
// The reference is a bit-serial LFSR, s_n = d_n ^ s_(n-39) ^ s_(n-58), kept as a bit queue.
// A bit-serial descrambler closes the loop during the streaming phase.
module tb_scrambler_66_64;

  localparam logic [57:0] SEED   = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FIRST0 = 64'h03FF_FF80_0000_0000;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic [1:0]  in_header = 2'b01;
  logic        scr_bypass = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [1:0]  out_header;
  logic        hdr_err;

  scrambler_66_64 #(.SEED(SEED)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_header(in_header), .scr_bypass(scr_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_header(out_header), .hdr_err(hdr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        err;
    logic [63:0] din;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  bit   sh[$];        // scrambler line history, front = oldest transmitted bit
  bit   dh[$];        // loopback descrambler history
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   lb_en    = 1'b0;
  int   lb_skip  = 0;
  int   n_beats  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sh.delete();
    for (int j = 0; j < 58; j++) sh.push_back(SEED[j]);
  endtask

  // Serial reference scrambler: one bit at a time, bit 0 transmitted first.
  task automatic model_push(input logic [63:0] d, input logic [1:0] h, input bit byp);
    exp_t        e;
    logic [63:0] s;
    bit          b;
    for (int i = 0; i < 64; i++) begin
      b    = d[i] ^ sh[19] ^ sh[0];
      s[i] = b;
      sh.push_back(b);
      void'(sh.pop_front());
    end
    e.data   = byp ? d : s;
    e.hdr    = h;
    e.err    = (h == 2'b00) || (h == 2'b11);
    e.din    = d;
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] h, input bit byp);
    bit got = 1'b0;
    in_valid = 1'b1; in_data = d; in_header = h; scr_bypass = byp;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge CLK);
      #1;
      if (in_ready) begin
        model_push(d, h, byp);
        got = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    scr_bypass = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", d);
    end
  endtask

  // Monitor: checks the handshake every cycle and pops/compares on each consumed beat.
  always @(negedge CLK) begin
    exp_t        e;
    logic [63:0] dd;
    bit          b;
    if (!rst && started) begin
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((sb.size() == 0) || out_ready));
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        n_beats++;
        $display("beat %0d: data=%h hdr=%b err=%b (exp %h %b %b)",
                 n_beats, out_data, out_header, hdr_err, e.data, e.hdr, e.err);
        chk("out_data", out_data, e.data);
        chk("out_header", 64'(out_header), 64'(e.hdr));
        chk("hdr_err", 64'(hdr_err), 64'(e.err));
        if (lb_en) begin
          for (int i = 0; i < 64; i++) begin
            b     = out_data[i];
            dd[i] = b ^ dh[19] ^ dh[0];
            dh.push_back(b);
            void'(dh.pop_front());
          end
          if (lb_skip > 0) lb_skip--;
          else chk("loopback", dd, e.din);
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  h;
    model_reset();
    for (int j = 0; j < 58; j++) dh.push_back(1'b0);

    // Reset and check the reset state of the outputs.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_header", 64'(out_header), 64'd0);
    chk("rst_hdr_err", 64'(hdr_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    started = 1'b1;
    step();

    // Scenario 1: the first zero word from the SEED state.
    send(64'd0, 2'b01, 1'b0);
    chk("first_zero_word", out_data, FIRST0);

    // Scenario 2: stream 1000 random beats at full rate, with the descrambler looped back.
    lb_en = 1'b1;
    lb_skip = 1;
    for (int k = 0; k < 1000; k++) begin
      d = {$urandom, $urandom};
      h = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      send(d, h, 1'b0);
    end
    step();
    step();
    lb_en = 1'b0;

    // Scenario 3: stall for 5 cycles with a beat waiting at the input.
    repeat (3) step();
    out_ready = 1'b0;
    send({$urandom, $urandom}, 2'b01, 1'b0);
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    in_header = 2'b10;
    d = in_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      #1;
      chk("stall_data", out_data, last_exp.data);
      chk("stall_header", 64'(out_header), 64'(last_exp.hdr));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    send(d, 2'b10, 1'b0);
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 2'b01, 1'b0);

    // Scenario 4: bad headers are flagged but still forwarded.
    send({$urandom, $urandom}, 2'b11, 1'b0);
    send({$urandom, $urandom}, 2'b01, 1'b0);
    send({$urandom, $urandom}, 2'b00, 1'b0);
    send({$urandom, $urandom}, 2'b10, 1'b0);

    // Scenario 5: a single bypass beat, followed by normal beats.
    send({$urandom, $urandom}, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 2'b01, 1'b0);

    // Mixed phase: random backpressure, gaps, headers and bypass.
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) step();
      send({$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Scenario 6: assert reset while a beat is held.
    out_ready = 1'b0;
    send({$urandom, $urandom}, 2'b10, 1'b0);
    rst = 1'b1;
    sb.delete();
    model_reset();
    step();
    rst = 1'b0;
    @(negedge CLK);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    send(64'd0, 2'b01, 1'b0);
    chk("post_rst_zero_word", out_data, FIRST0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int n = 0; n < 100 && sb.size() != 0; n++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
